dump_console_tx: RTL and testbench
==================================

// Module: dump_console_tx
// PURPOSE
//  Debug console serialiser downstream of the single-cycle CPU (scpu). Each rising
//  edge of the CPU's dump-state strobe queues the low byte of r2 as a character.
//  A UART 8N1 transmitter drains the queue onto a serial line.
//  On halt it reports when every queued character has left the wire, so the bench
//  or top level can delay $finish / power-down until then.
// PARAMETERS
//  CLKS_PER_BIT  4  clk cycles per UART bit; >=2
//  FIFO_DEPTH    4  queued characters; power of 2, >=2
// PORTS
//  clk         in   1  single clock, all state on posedge
//  reset_n     in   1  asynchronous, active-low reset
//  dump_state  in   1  CPU dump strobe (level; edge-detected here)
//  dump_char   in   8  character to queue (CPU r2[7:0]), sampled with the edge
//  halt        in   1  CPU halt (level)
//  txd         out  1  UART serial out, idle high
//  tx_busy     out  1  frame in progress (state != IDLE)
//  fifo_full   out  1  queue holds FIFO_DEPTH entries
//  overflow    out  1  sticky: a character was dropped
//  drained     out  1  halt seen, queue empty, transmitter idle
// BEHAVIOUR
//  Reset (async assert, sync-style release): txd=1, tx_busy=0, fifo_full=0,
//   overflow=0, drained=0, queue emptied, dump_state history=0, halt_seen=0.
//   Assert mid-frame aborts it: txd returns high immediately.
//  Push: posedge k with dump_state=1 and previous sample 0 writes dump_char.
//   Level held high = exactly one push. Push with queue full and no pop in the
//   same cycle: dropped, overflow<=1 until reset.
//  Simultaneous push+pop when full: both happen; no drop, count unchanged.
//  TX FSM states IDLE, START, DATA, STOP; bit counter 0..CLKS_PER_BIT-1,
//   bit index 0..7.
//   IDLE: queue non-empty -> pop into shift reg, go START. Else stay; txd=1.
//   START: txd=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA: txd=shift[0], LSB first; shift right every CLKS_PER_BIT cycles;
//    after bit 7 -> STOP.
//   STOP: txd=1 for CLKS_PER_BIT cycles -> IDLE.
//  Latency: push at posedge k -> pop at k+1 -> txd low from k+1.
//   Frame = 10*CLKS_PER_BIT cycles.
//   Back-to-back frames are separated by exactly one IDLE cycle (txd=1).
//  txd is driven from a register; it is glitch-free.
//  halt_seen: sticky, set on first posedge with halt=1.
//   drained = halt_seen && empty && state==IDLE.
//   Pushes after halt are still accepted; drained drops until they are sent.
//  Pointers: log2(FIFO_DEPTH) bits plus wrap bit; full/empty come from the wrap
//   compare; wrap-around is silent.
// STRUCTURE
//  Package dump_console_pkg: tx_state_t enum {IDLE,START,DATA,STOP};
//   localparam UART_DATA_BITS=8.
//  Sub-module byte_fifo (synchronous FIFO, DEPTH param, push/pop/full/empty/dout),
//   instantiated once. FSM, baud counter, edge detect and drained logic stay in
//   dump_console_tx.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 One pulse, dump_char=8'h41 -> txd: 4 low, bits 1,0,0,0,0,0,1,0 (4 cycles
//    each), 4 high; tx_busy high 40 cycles; overflow=0.
//  2 dump_state held high 10 cycles, char 8'h5A -> exactly one frame; second
//    frame only after a low-then-high edge.
//  3 Six pulses 2 cycles apart while idle -> 1st goes straight to TX, 4 queued,
//    6th dropped: overflow=1, fifo_full=1; exactly 5 frames sent, in order.
//  4 Two chars queued, then halt=1 -> drained=0 until the 2nd stop bit ends
//    (~81 cycles), then 1; another push -> drained falls, rises after its frame.
//  5 reset_n low 1 cycle mid-DATA of frame 1 with 2 queued -> txd=1
//    asynchronously, queue empty, no further frames, all outputs at reset values.
//  6 Full queue, push on the same posedge as the IDLE pop -> no overflow; all 5
//    chars emitted.

Source files
------------

// File: rtl/dump_console_pkg.sv
// Shared types and constants for the debug console UART serialiser.
package dump_console_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BIT_IDX_W      = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/dump_console_tx_if.sv
// CPU-side strobes into the console and the serial/status lines coming back out.
interface dump_console_tx_if;
  import dump_console_pkg::*;

  logic                      dump_state;
  logic [UART_DATA_BITS-1:0] dump_char;
  logic                      halt;
  logic                      txd;
  logic                      tx_busy;
  logic                      fifo_full;
  logic                      overflow;
  logic                      drained;

  // CPU / bench side
  modport master (
    output dump_state, dump_char, halt,
    input  txd, tx_busy, fifo_full, overflow, drained
  );

  // Console side
  modport slave (
    input  dump_state, dump_char, halt,
    output txd, tx_busy, fifo_full, overflow, drained
  );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO with wrap-bit pointers; combinational read of the head entry.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] mem [DEPTH];

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[PTR_W-1:0]];

  // Pointer advance; wrap-around through the extra bit is silent.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; the pointers alone define which entries are
  // valid, and leaving it unreset lets it map onto plain RAM/register cells.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/dump_console_tx.sv
// Debug console: edge-detects the CPU dump strobe, queues r2[7:0] and sends each
// character as a UART 8N1 frame; reports when everything has left the wire on halt.
module dump_console_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  dump_console_tx_if.slave   bus
);
  import dump_console_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_t                 state;
  tx_state_t                 state_d;
  logic [CNT_W-1:0]          baud_cnt;
  logic [CNT_W-1:0]          baud_cnt_d;
  logic [BIT_IDX_W-1:0]      bit_idx;
  logic [BIT_IDX_W-1:0]      bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic                      txd_q;
  logic                      txd_d;
  logic                      baud_last;

  logic                      dump_prev;
  logic                      halt_seen;
  logic                      overflow_q;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;

  assign push      = bus.dump_state && !dump_prev;
  assign baud_last = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (bus.dump_char),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Strobe history, sticky halt and sticky drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dump_prev  <= 1'b0;
      halt_seen  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dump_prev <= bus.dump_state;
      if (bus.halt) halt_seen <= 1'b1;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  // FSM state register plus the serial datapath and the registered txd.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  // Next-state logic: baud pacing, bit sequencing and the queue pop.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_dout;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_idx == BIT_IDX_W'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the upcoming cycle, taken from the next state so the
  // registered txd lines up with the state it belongs to.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign bus.txd       = txd_q;
  assign bus.tx_busy   = (state != IDLE);
  assign bus.fifo_full = fifo_full;
  assign bus.overflow  = overflow_q;
  assign bus.drained   = halt_seen && fifo_empty && (state == IDLE);

endmodule

// File: tb/tb_dump_console_tx.sv
// Directed bench for dump_console_tx: stimulus pushes expected characters into a
// scoreboard, a line monitor decodes each UART frame and pops/compares.
module tb_dump_console_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  dump_console_tx_if bus ();

  dump_console_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         frames   = 0;
  logic [7:0] sb [$];

  logic             mon_busy = 1'b0;
  int               mon_pos  = 0;
  logic [FRAME-1:0] samp;
  logic             busy_all;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decode one captured frame and compare it against the scoreboard head.
  task automatic check_frame();
    logic [7:0] data;
    logic       stable;
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data[i] = samp[CPB*(i+1)];
      if (samp[CPB*(i+1) +: CPB] != {CPB{samp[CPB*(i+1)]}}) stable = 1'b0;
    end
    frames++;
    check("start_bit", samp[CPB-1:0], 0);
    check("stop_bit", samp[FRAME-1 -: CPB], {CPB{1'b1}});
    check("bit_stable", stable, 1);
    check("busy_in_frame", busy_all, 1);
    check("frame_expected", sb.size() != 0, 1);
    if (sb.size() != 0) check("frame_data", data, sb.pop_front());
  endtask

  // Line monitor: a low level while idle starts a frame; a reset aborts it.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        mon_busy = 1'b0;
      end else if (!mon_busy) begin
        if (bus.txd === 1'b0) begin
          mon_busy = 1'b1;
          mon_pos  = 1;
          samp     = '1;
          samp[0]  = 1'b0;
          busy_all = bus.tx_busy;
        end
      end else begin
        samp[mon_pos] = bus.txd;
        busy_all      = busy_all & bus.tx_busy;
        mon_pos++;
        if (mon_pos == FRAME) begin
          mon_busy = 1'b0;
          check_frame();
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse(input logic [7:0] c, input bit accept);
    @(negedge clk);
    bus.dump_char  = c;
    bus.dump_state = 1'b1;
    if (accept) sb.push_back(c);
    @(negedge clk);
    bus.dump_state = 1'b0;
  endtask

  // Wait until every expected character has been seen and the line is idle.
  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.tx_busy || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
    check("idle_after_drain", bus.tx_busy, 0);
  endtask

  initial begin : stimulus
    int f0;
    int n;
    logic all_high;
    logic busy_low;

    reset_n        = 1'b0;
    bus.dump_state = 1'b0;
    bus.dump_char  = 8'h00;
    bus.halt       = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd", bus.txd, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_full", bus.fifo_full, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_drained", bus.drained, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single pulse 'A', one-cycle latency from push to start bit
    bus.dump_char  = 8'h41;
    bus.dump_state = 1'b1;
    sb.push_back(8'h41);
    @(negedge clk);
    bus.dump_state = 1'b0;
    check("t1_txd_after_push", bus.txd, 1);
    check("t1_busy_after_push", bus.tx_busy, 0);
    @(negedge clk);
    check("t1_txd_start", bus.txd, 0);
    check("t1_busy_start", bus.tx_busy, 1);
    wait_done("t1_done", 200);
    check("t1_frames", frames, 1);
    check("t1_overflow", bus.overflow, 0);

    // 2: level held high 10 cycles is one push; a fresh edge is another
    @(negedge clk);
    bus.dump_char  = 8'h5A;
    bus.dump_state = 1'b1;
    sb.push_back(8'h5A);
    repeat (10) @(negedge clk);
    bus.dump_state = 1'b0;
    wait_done("t2_held_done", 200);
    check("t2_frames_held", frames, 2);
    pulse(8'h5A, 1'b1);
    wait_done("t2_edge_done", 200);
    check("t2_frames_edge", frames, 3);

    // 3: six pulses while idle: one in flight, four queued, sixth dropped
    f0 = frames;
    for (int i = 0; i < 6; i++) pulse(8'h31 + 8'(i), i < 5);
    check("t3_overflow", bus.overflow, 1);
    check("t3_full", bus.fifo_full, 1);
    wait_done("t3_done", 400);
    check("t3_frames", frames - f0, 5);
    check("t3_overflow_sticky", bus.overflow, 1);

    // 4: two characters then halt; drained waits for the second stop bit
    @(negedge clk);
    bus.dump_char  = 8'hC3;
    bus.dump_state = 1'b1;
    sb.push_back(8'hC3);
    @(negedge clk);
    bus.dump_state = 1'b0;
    n = 0;
    @(negedge clk);
    n++;
    bus.dump_char  = 8'h7E;
    bus.dump_state = 1'b1;
    sb.push_back(8'h7E);
    @(negedge clk);
    n++;
    bus.dump_state = 1'b0;
    bus.halt       = 1'b1;
    check("t4_drained_early", bus.drained, 0);
    while (!bus.drained && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t4_drain_cycles", n, 82);
    check("t4_sb_empty", sb.size(), 0);
    pulse(8'h99, 1'b1);
    check("t4_drained_falls", bus.drained, 0);
    n = 0;
    while (!bus.drained && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_drained_rises", bus.drained, 1);
    check("t4_sb_empty2", sb.size(), 0);
    bus.halt = 1'b0;

    // 5: reset mid-DATA of a 0x00 frame with two queued
    f0 = frames;
    pulse(8'h00, 1'b1);
    pulse(8'hFF, 1'b1);
    pulse(8'h0F, 1'b1);
    repeat (12) @(negedge clk);
    check("t5_txd_low_before", bus.txd, 0);
    #1 reset_n = 1'b0;
    #1;
    check("t5_txd_async", bus.txd, 1);
    check("t5_busy", bus.tx_busy, 0);
    check("t5_full", bus.fifo_full, 0);
    check("t5_overflow", bus.overflow, 0);
    check("t5_drained", bus.drained, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    sb.delete();
    all_high = 1'b1;
    busy_low = 1'b1;
    repeat (100) begin
      @(negedge clk);
      all_high = all_high & bus.txd;
      busy_low = busy_low & !bus.tx_busy;
    end
    check("t5_txd_idle", all_high, 1);
    check("t5_no_busy", busy_low, 1);
    check("t5_no_frames", frames - f0, 0);
    check("t5_overflow_after", bus.overflow, 0);

    // 6: full queue, push lands on the same edge as the IDLE pop
    f0 = frames;
    for (int i = 0; i < 5; i++) pulse(8'hA1 + 8'(i), 1'b1);
    check("t6_full", bus.fifo_full, 1);
    check("t6_overflow_pre", bus.overflow, 0);
    n = 0;
    while (bus.tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_idle_gap", bus.tx_busy, 0);
    check("t6_full_at_gap", bus.fifo_full, 1);
    bus.dump_char  = 8'hA6;
    bus.dump_state = 1'b1;
    sb.push_back(8'hA6);
    @(negedge clk);
    bus.dump_state = 1'b0;
    check("t6_overflow_post", bus.overflow, 0);
    check("t6_full_post", bus.fifo_full, 1);
    check("t6_busy_post", bus.tx_busy, 1);
    wait_done("t6_done", 400);
    // the character in flight plus the five that shared the queue
    check("t6_frames", frames - f0, 6);
    check("t6_overflow_end", bus.overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
